// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: run controller for the serial pattern detector.
//
// A start pulse with a legal configuration latches the pattern, its length and
// the window length, then the controller scans exactly cfg_window bits of x,
// counting (optionally non-overlapping) pattern matches, and parks in DONE
// with the final count until the next accepted start.
//
// Optional feature macro: SEQ_NONOVERLAP_EN
//   defined   -> a match clears bits_seen, so matches never overlap
//   undefined -> overlapping matches are counted
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous, active-high reset
//   start       in   single-cycle run request
//   cfg_pattern in   pattern; bit[cfg_len-1] is the first bit expected
//   cfg_len     in   pattern length, legal 1..PAT_MAX
//   cfg_window  in   number of bits to scan, legal >= 1
//   x           in   serial data, sampled every rising edge in SCAN
//   busy        out  high while scanning
//   match       out  one-cycle pulse per detected match
//   count       out  matches in current/last run (saturating)
//   overflow    out  count saturated in current/last run (sticky)
//   done        out  high in DONE until the next accepted start
//   cfg_err     out  one-cycle pulse when a start is rejected
module seq_scan_ctrl #(
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 10,
    parameter int WIN_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PAT_MAX-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic [WIN_W-1:0]   cfg_window,
    input  logic               x,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    output logic               done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e             state_q, state_d;
    logic [PAT_MAX-1:0] pat_q, pat_d;
    logic [3:0]         len_q, len_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [PAT_MAX-1:0] shift_q, shift_d;
    logic [3:0]         seen_q, seen_d;
    logic               busy_q, busy_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               cfg_ok;
    logic [PAT_MAX-1:0] len_mask;
    logic [PAT_MAX-1:0] shift_upd;
    logic [3:0]         seen_upd;
    logic               hit;

    assign cfg_ok = (cfg_len != 4'd0) && (int'(cfg_len) <= PAT_MAX) && (cfg_window != '0);

    // Only the low len_q bits of pattern and shift register take part in a compare.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            len_mask[i] = (i < int'(len_q));
        end
    end

    // Match is judged on the values the current edge will store.
    assign shift_upd = {shift_q[PAT_MAX-2:0], x};
    assign seen_upd  = (seen_q == len_q) ? seen_q : seen_q + 4'd1;
    assign hit       = (seen_upd == len_q) && ((shift_upd & len_mask) == (pat_q & len_mask));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pat_q   <= '0;
            len_q   <= '0;
            win_q   <= '0;
            shift_q <= '0;
            seen_q  <= '0;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            win_q   <= win_d;
            shift_q <= shift_d;
            seen_q  <= seen_d;
            busy_q  <= busy_d;
            match_q <= match_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        win_d   = win_q;
        shift_d = shift_q;
        seen_d  = seen_q;
        busy_d  = busy_q;
        match_d = 1'b0;
        count_d = count_q;
        ovf_d   = ovf_q;
        done_d  = done_q;
        err_d   = 1'b0;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    if (cfg_ok) begin
                        pat_d   = cfg_pattern;
                        len_d   = cfg_len;
                        win_d   = cfg_window;
                        shift_d = '0;
                        seen_d  = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                        state_d = StScan;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StScan: begin
                shift_d = shift_upd;
                seen_d  = seen_upd;
                win_d   = win_q - WIN_W'(1);
                if (hit) begin
                    match_d = 1'b1;
                    if (&count_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
`ifdef SEQ_NONOVERLAP_EN
                    seen_d = '0;
`else
                    seen_d = seen_upd;
`endif
                end
                // win_q == 1 means this edge samples the final window bit.
                if (win_q == WIN_W'(1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy     = busy_q;
    assign match    = match_q;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign done     = done_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed testbench for seq_scan_ctrl. A default-sized instance covers the
// overlap run, rejected starts, back-to-back start, ignored mid-run start and
// mid-run reset; a CNT_W=2 instance covers counter saturation.
module tb_seq_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, x;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic [11:0] cfg_window;
    logic        busy, match, overflow, done, cfg_err;
    logic [9:0]  count;

    logic        s_start, s_x;
    logic [7:0]  s_cfg_pattern;
    logic [3:0]  s_cfg_len;
    logic [11:0] s_cfg_window;
    logic        s_busy, s_match, s_overflow, s_done, s_cfg_err;
    logic [1:0]  s_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_scan_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_window(cfg_window), .x(x), .busy(busy),
        .match(match), .count(count), .overflow(overflow), .done(done),
        .cfg_err(cfg_err)
    );

    seq_scan_ctrl #(.PAT_MAX(8), .CNT_W(2), .WIN_W(12)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .cfg_pattern(s_cfg_pattern),
        .cfg_len(s_cfg_len), .cfg_window(s_cfg_window), .x(s_x), .busy(s_busy),
        .match(s_match), .count(s_count), .overflow(s_overflow), .done(s_done),
        .cfg_err(s_cfg_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic seq   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic exp_m [8];
    int   exp_cnt;
    int   ov_final;
    int   mid5_cnt;

    initial begin
`ifdef SEQ_NONOVERLAP_EN
        exp_m    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        ov_final = 2;
        mid5_cnt = 1;
`else
        exp_m    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        ov_final = 3;
        mid5_cnt = 2;
`endif
        rst = 1'b1; start = 1'b0; x = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_window = '0;
        s_start = 1'b0; s_x = 1'b0;
        s_cfg_pattern = '0; s_cfg_len = '0; s_cfg_window = '0;

        // Reset state
        #2;
        check("rst_busy", 32'(busy), 0);
        check("rst_match", 32'(match), 0);
        check("rst_count", 32'(count), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(cfg_err), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("idle_busy", 32'(busy), 0);

        // Overlapping run: pattern 010 over 01010010
        cfg_pattern = 8'h02; cfg_len = 4'd3; cfg_window = 12'd8; start = 1'b1;
        tick();
        start = 1'b0;
        check("ov_start_busy", 32'(busy), 1);
        check("ov_start_done", 32'(done), 0);
        check("ov_start_count", 32'(count), 0);
        exp_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            x = seq[i];
            tick();
            if (exp_m[i]) exp_cnt++;
            check($sformatf("ov_match%0d", i), 32'(match), 32'(exp_m[i]));
            check($sformatf("ov_count%0d", i), 32'(count), 32'(exp_cnt));
            check($sformatf("ov_busy%0d", i), 32'(busy), 32'(i != 7));
            check($sformatf("ov_done%0d", i), 32'(done), 32'(i == 7));
        end
        check("ov_final_count", 32'(count), 32'(ov_final));
        check("ov_final_ovf", 32'(overflow), 0);
        tick();
        check("ov_hold_match", 32'(match), 0);
        check("ov_hold_done", 32'(done), 1);
        check("ov_hold_count", 32'(count), 32'(ov_final));

        // Rejected starts from DONE
        cfg_len = 4'd0; cfg_window = 12'd8; start = 1'b1;
        tick();
        start = 1'b0;
        check("err_len0", 32'(cfg_err), 1);
        check("err_len0_busy", 32'(busy), 0);
        check("err_len0_done", 32'(done), 1);
        check("err_len0_count", 32'(count), 32'(ov_final));
        tick();
        check("err_pulse_end", 32'(cfg_err), 0);
        cfg_len = 4'd3; cfg_window = 12'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check("err_win0", 32'(cfg_err), 1);
        check("err_win0_busy", 32'(busy), 0);
        check("err_win0_done", 32'(done), 1);
        check("err_win0_count", 32'(count), 32'(ov_final));
        cfg_len = 4'd9; cfg_window = 12'd8; start = 1'b1;
        tick();
        start = 1'b0;
        check("err_len9", 32'(cfg_err), 1);
        check("err_len9_busy", 32'(busy), 0);

        // Back-to-back start from DONE, with an ignored start at bit 4
        cfg_pattern = 8'h02; cfg_len = 4'd3; cfg_window = 12'd8; start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_done", 32'(done), 0);
        check("b2b_busy", 32'(busy), 1);
        check("b2b_count", 32'(count), 0);
        check("b2b_err", 32'(cfg_err), 0);
        for (int i = 0; i < 8; i++) begin
            x = seq[i];
            if (i == 3) begin
                start = 1'b1; cfg_pattern = 8'hff; cfg_len = 4'd1; cfg_window = 12'd2;
            end
            tick();
            start = 1'b0;
            check($sformatf("mid_match%0d", i), 32'(match), 32'(exp_m[i]));
            check($sformatf("mid_done%0d", i), 32'(done), 32'(i == 7));
            check($sformatf("mid_err%0d", i), 32'(cfg_err), 0);
        end
        check("mid_final_count", 32'(count), 32'(ov_final));

        // Reset in the middle of a run, while a match pulse is high
        cfg_pattern = 8'h02; cfg_len = 4'd3; cfg_window = 12'd8; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            x = seq[i];
            tick();
        end
        check("pre_rst_match", 32'(match), 32'(exp_m[4]));
        check("pre_rst_count", 32'(count), 32'(mid5_cnt));
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_count", 32'(count), 0);
        check("arst_match", 32'(match), 0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_done", 32'(done), 0);

        // Clean run after reset: pattern 1, window 3, x = 1,0,1
        cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_window = 12'd3; start = 1'b1;
        tick();
        start = 1'b0;
        check("clean_start_count", 32'(count), 0);
        check("clean_start_busy", 32'(busy), 1);
        x = 1'b1; tick();
        check("clean_m0", 32'(match), 1);
        check("clean_c0", 32'(count), 1);
        x = 1'b0; tick();
        check("clean_m1", 32'(match), 0);
        check("clean_c1", 32'(count), 1);
        check("clean_d1", 32'(done), 0);
        x = 1'b1; tick();
        check("clean_m2", 32'(match), 1);
        check("clean_c2", 32'(count), 2);
        check("clean_d2", 32'(done), 1);
        check("clean_b2", 32'(busy), 0);

        // Saturation on the 2-bit counter instance
        s_cfg_pattern = 8'h01; s_cfg_len = 4'd1; s_cfg_window = 12'd6; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        check("sat_busy", 32'(s_busy), 1);
        for (int i = 0; i < 6; i++) begin
            s_x = 1'b1;
            tick();
            check($sformatf("sat_match%0d", i), 32'(s_match), 1);
            check($sformatf("sat_count%0d", i), 32'(s_count), 32'((i + 1 > 3) ? 3 : i + 1));
            check($sformatf("sat_ovf%0d", i), 32'(s_overflow), 32'(i >= 3));
            check($sformatf("sat_done%0d", i), 32'(s_done), 32'(i == 5));
        end
        tick();
        check("sat_hold_count", 32'(s_count), 3);
        check("sat_hold_ovf", 32'(s_overflow), 1);
        check("sat_hold_done", 32'(s_done), 1);
        check("sat_hold_match", 32'(s_match), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
